// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The controller side drives the operands and start; the subtractor side returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, ovf
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// A single full-subtractor cell feeds a borrow flop; the result is held until the next accepted start.
module serial_subtractor #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_out_q, borrow_out_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy;

  logic               last_bit;
  logic               diff_bit;
  logic               br_next;

  assign last_bit = (state_q == RUN) && (count_q == CNT_W'(WIDTH - 1));
  assign diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_next  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
  end

  // Datapath: capture on accepted start, shift one bit per RUN cycle
  always_comb begin
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_sh_d     = res_sh_q;
    br_d         = br_q;
    count_d      = count_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        a_sh_d   = bus.a;
        b_sh_d   = bus.b;
        br_d     = bus.borrow_in;
        res_sh_d = '0;
        count_d  = '0;
      end
    end else begin
      res_sh_d = {diff_bit, res_sh_q[WIDTH-1:1]};
      a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
      br_d     = br_next;
      count_d  = count_q + CNT_W'(1);
      if (last_bit) begin
        // On the last bit the shifter LSBs are the original operand MSBs.
        diff_d       = {diff_bit, res_sh_q[WIDTH-1:1]};
        borrow_out_d = br_next;
        ovf_d        = (a_sh_q[0] != b_sh_q[0]) && (diff_bit != a_sh_q[0]);
        done_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_sh_q     <= '0;
      br_q         <= 1'b0;
      count_q      <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_sh_q     <= res_sh_d;
      br_q         <= br_d;
      count_q      <= count_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.ovf        = ovf_q;

endmodule
